// File: rtl/sd2vc_mc.sv
// sd2vc_mc: multi-channel srdy/drdy to valid/credit converter.
// Each channel has its own 1-entry holding register and credit counter.
// A round-robin arbiter sends at most one held word per cycle onto the
// shared registered link (p_vld/p_vc/p_data).
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   c_srdy/c_drdy    per-channel producer handshake
//   c_data           channel i data at [i*width +: width]
//   p_vld/p_vc/p_data  registered link word, channel id and data
//   p_cr             per-channel credit return, one credit per set bit per cycle
//   cr_err           sticky flag: a credit was returned to a saturated counter

// Per-channel lane: holding register plus credit counter.
module sd2vc_mc_ch #(
   parameter int width        = 8,
   parameter int cc_sz        = 5,
   parameter int init_credits = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             srdy,
   input  logic [width-1:0] data,
   input  logic             grant,
   input  logic             cr,
   output logic             drdy,
   output logic             hold_vld,
   output logic [width-1:0] hold_data,
   output logic             eligible,
   output logic             cr_ovf
);
   localparam logic [cc_sz-1:0] CR_MAX  = '1;
   localparam logic [cc_sz-1:0] CR_INIT = cc_sz'(init_credits);

   logic [cc_sz-1:0] credit;

   // Holding register can accept a new word whenever it is empty or its
   // current word leaves this cycle; never depends on srdy.
   assign drdy     = ~hold_vld | grant;
   assign eligible = hold_vld & (credit != '0);
   // A return that would push a full counter past its maximum.
   assign cr_ovf   = cr & ~grant & (credit == CR_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_vld  <= 1'b0;
         hold_data <= '0;
         credit    <= CR_INIT;
      end else begin
         if (srdy & drdy) begin
            hold_vld  <= 1'b1;
            hold_data <= data;
         end else if (grant) begin
            hold_vld  <= 1'b0;
         end
         // Grant and return in the same cycle cancel out.
         case ({grant, cr})
            2'b10:   credit <= credit - 1'b1;
            2'b01:   if (credit != CR_MAX) credit <= credit + 1'b1;
            default: ;
         endcase
      end
   end
endmodule

module sd2vc_mc #(
   parameter int width        = 8,
   parameter int channels     = 4,
   parameter int cc_sz        = 5,
   parameter int init_credits = 8,
   localparam int vc_sz       = (channels > 1) ? $clog2(channels) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [channels-1:0]       c_srdy,
   output logic [channels-1:0]       c_drdy,
   input  logic [channels*width-1:0] c_data,
   output logic                      p_vld,
   output logic [vc_sz-1:0]          p_vc,
   output logic [width-1:0]          p_data,
   input  logic [channels-1:0]       p_cr,
   output logic                      cr_err
);
   logic [channels-1:0]            eligible;
   logic [channels-1:0]            grant;
   logic [channels-1:0]            cr_ovf;
   logic [channels-1:0]            hold_vld;
   logic [channels-1:0][width-1:0] hold_data;
   logic [vc_sz-1:0]               rr_ptr;
   logic [vc_sz-1:0]               gnt_idx;
   logic                           gnt_any;

   for (genvar i = 0; i < channels; i++) begin : g_ch
      sd2vc_mc_ch #(
         .width       (width),
         .cc_sz       (cc_sz),
         .init_credits(init_credits)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .srdy     (c_srdy[i]),
         .data     (c_data[i*width +: width]),
         .grant    (grant[i]),
         .cr       (p_cr[i]),
         .drdy     (c_drdy[i]),
         .hold_vld (hold_vld[i]),
         .hold_data(hold_data[i]),
         .eligible (eligible[i]),
         .cr_ovf   (cr_ovf[i])
      );
   end

   // Round-robin: scan from last granted+1, wrapping, so the last granted
   // channel is considered last.
   always_comb begin
      int idx;
      idx     = 0;
      grant   = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 1; k <= channels; k++) begin
         idx = (int'(rr_ptr) + k) % channels;
         if (!gnt_any && eligible[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = vc_sz'(idx);
         end
      end
      if (gnt_any) grant[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= vc_sz'(channels - 1);
         p_vld  <= 1'b0;
         p_vc   <= '0;
         p_data <= '0;
         cr_err <= 1'b0;
      end else begin
         p_vld <= gnt_any;
         if (gnt_any) begin
            rr_ptr <= gnt_idx;
            p_vc   <= gnt_idx;
            p_data <= hold_data[gnt_idx];
         end
         if (|cr_ovf) cr_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sd2vc_mc.sv
module tb_sd2vc_mc;
   localparam int W    = 8;
   localparam int CH   = 4;
   localparam int CC   = 5;
   localparam int INIT = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [CH-1:0]   c_srdy, c_drdy, p_cr;
   logic [CH*W-1:0] c_data;
   logic            p_vld;
   logic [1:0]      p_vc;
   logic [W-1:0]    p_data;
   logic            cr_err;

   int n_chk  = 0;
   int n_fail = 0;

   // Values sampled at the negedge of the last step.
   logic [CH-1:0] hs;
   logic          bv;
   logic [1:0]    bvc;
   logic [W-1:0]  bd;

   always #5 clk = ~clk;

   sd2vc_mc #(.width(W), .channels(CH), .cc_sz(CC), .init_credits(INIT)) dut (
      .clk   (clk),
      .reset (reset),
      .c_srdy(c_srdy),
      .c_drdy(c_drdy),
      .c_data(c_data),
      .p_vld (p_vld),
      .p_vc  (p_vc),
      .p_data(p_data),
      .p_cr  (p_cr),
      .cr_err(cr_err)
   );

   // Drive inputs just after a rising edge, sample at the following negedge.
   task automatic step(input logic [CH-1:0] s, input logic [CH*W-1:0] d, input logic [CH-1:0] cr);
      @(posedge clk); #1;
      c_srdy = s; c_data = d; p_cr = cr;
      @(negedge clk);
      hs = c_srdy & c_drdy; bv = p_vld; bvc = p_vc; bd = p_data;
   endtask

   task automatic do_reset;
      c_srdy = '0; c_data = '0; p_cr = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
   endtask

   task automatic test_reset;
      c_srdy = '0; c_data = '0; p_cr = '0;
      reset = 1'b1;
      #12;
      n_chk++; if (p_vld !== 1'b0 || cr_err !== 1'b0 || p_vc !== 2'd0 || p_data !== 8'd0) begin
         n_fail++; $display("FAIL reset_outs: p_vld=%b cr_err=%b p_vc=%0d p_data=%h, want 0s", p_vld, cr_err, p_vc, p_data);
      end
      #10 reset = 1'b0;
      @(negedge clk);
      n_chk++; if (c_drdy !== 4'hF) begin
         n_fail++; $display("FAIL reset_drdy: got %h want f", c_drdy);
      end
      for (int i = 0; i < 10; i++) begin
         step('0, '0, '0);
         n_chk++; if (bv !== 1'b0) begin
            n_fail++; $display("FAIL idle_vld cyc %0d: got %b want 0", i, bv);
         end
      end
   endtask

   task automatic test_ch0_stream;
      int k, nb, hs_cyc, first_beat;
      k = 0; nb = 0; hs_cyc = -1; first_beat = -1;
      do_reset();
      for (int cyc = 0; cyc < 40; cyc++) begin
         step((k < 10) ? 4'b0001 : 4'b0000, {24'h0, 8'(k)}, '0);
         if (bv) begin
            if (first_beat < 0) first_beat = cyc;
            n_chk++; if (bvc !== 2'd0 || bd !== 8'(nb)) begin
               n_fail++; $display("FAIL ch0_beat %0d: vc=%0d data=%h want vc=0 data=%h", nb, bvc, bd, 8'(nb));
            end
            nb++;
         end
         if (hs[0]) begin
            if (hs_cyc < 0) hs_cyc = cyc;
            k++;
         end
      end
      n_chk++; if (first_beat - hs_cyc !== 2) begin
         n_fail++; $display("FAIL ch0_latency: got %0d cycles want 2", first_beat - hs_cyc);
      end
      n_chk++; if (nb !== 8 || k !== 9 || c_drdy[0] !== 1'b0) begin
         n_fail++; $display("FAIL ch0_credit_stall: beats=%0d xfers=%0d drdy0=%b want 8 9 0", nb, k, c_drdy[0]);
      end
      for (int cyc = 0; cyc < 20; cyc++) begin
         step((k < 10) ? 4'b0001 : 4'b0000, {24'h0, 8'(k)}, (cyc == 0 || cyc == 5) ? 4'b0001 : 4'b0000);
         if (bv) begin
            n_chk++; if (bvc !== 2'd0 || bd !== 8'(nb)) begin
               n_fail++; $display("FAIL ch0_ret_beat %0d: vc=%0d data=%h want vc=0 data=%h", nb, bvc, bd, 8'(nb));
            end
            nb++;
         end
         if (hs[0]) k++;
      end
      n_chk++; if (nb !== 10) begin
         n_fail++; $display("FAIL ch0_total: got %0d beats want 10", nb);
      end
   endtask

   task automatic test_all_saturated;
      int cnt[CH], expd[CH];
      int expvc, beats;
      logic started;
      logic [CH-1:0] ret;
      logic [CH*W-1:0] d;
      for (int i = 0; i < CH; i++) begin cnt[i] = 0; expd[i] = 0; end
      expvc = 0; beats = 0; started = 1'b0; ret = '0;
      do_reset();
      for (int cyc = 0; cyc < 60; cyc++) begin
         for (int i = 0; i < CH; i++) d[i*W +: W] = 8'(cnt[i]);
         step('1, d, ret);
         ret = '0;
         for (int i = 0; i < CH; i++) if (hs[i]) cnt[i]++;
         if (started) begin
            n_chk++; if (bv !== 1'b1) begin
               n_fail++; $display("FAIL sat_gap cyc %0d: p_vld=%b want 1", cyc, bv);
            end
         end
         if (bv) begin
            started = 1'b1;
            ret[bvc] = 1'b1;
            n_chk++; if (bvc !== 2'(expvc) || bd !== 8'(expd[bvc])) begin
               n_fail++; $display("FAIL sat_beat %0d: vc=%0d data=%h want vc=%0d data=%h", beats, bvc, bd, expvc, 8'(expd[bvc]));
            end
            expd[bvc]++;
            expvc = (expvc + 1) % CH;
            beats++;
         end
      end
      n_chk++; if (beats < 55) begin
         n_fail++; $display("FAIL sat_beats: got %0d want >= 55", beats);
      end
   endtask

   task automatic test_credit_same_cycle;
      int k, nb;
      logic [CH-1:0] cr;
      k = 0; nb = 0; cr = '0;
      do_reset();
      for (int cyc = 0; cyc < 40; cyc++) begin
         step((k < 10) ? 4'b0100 : 4'b0000, {8'h0, 8'(k), 16'h0}, cr);
         cr = '0;
         if (bv) begin
            n_chk++; if (bvc !== 2'd2 || bd !== 8'(nb)) begin
               n_fail++; $display("FAIL ch2_beat %0d: vc=%0d data=%h want vc=2 data=%h", nb, bvc, bd, 8'(nb));
            end
            nb++;
         end
         if (hs[2]) begin
            k++;
            // 8th word enters the holding register: its grant cycle is next,
            // when exactly one credit is left.
            if (k == 8) cr = 4'b0100;
         end
      end
      n_chk++; if (nb !== 9 || c_drdy[2] !== 1'b0) begin
         n_fail++; $display("FAIL ch2_same_cycle: beats=%0d drdy2=%b want 9 0", nb, c_drdy[2]);
      end
   endtask

   task automatic test_saturation;
      int k, nb;
      k = 0; nb = 0;
      do_reset();
      for (int i = 0; i < 23; i++) step('0, '0, 4'b0010);
      step('0, '0, '0);
      n_chk++; if (cr_err !== 1'b0) begin
         n_fail++; $display("FAIL sat_no_err: cr_err=%b want 0", cr_err);
      end
      step('0, '0, 4'b0010);
      step('0, '0, '0);
      n_chk++; if (cr_err !== 1'b1) begin
         n_fail++; $display("FAIL sat_err_set: cr_err=%b want 1", cr_err);
      end
      repeat (5) step('0, '0, '0);
      n_chk++; if (cr_err !== 1'b1) begin
         n_fail++; $display("FAIL sat_err_sticky: cr_err=%b want 1", cr_err);
      end
      for (int cyc = 0; cyc < 50; cyc++) begin
         step((k < 40) ? 4'b0010 : 4'b0000, {16'h0, 8'(k), 8'h0}, '0);
         if (bv) nb++;
         if (hs[1]) k++;
      end
      n_chk++; if (nb !== 31 || cr_err !== 1'b1) begin
         n_fail++; $display("FAIL sat_count: beats=%0d cr_err=%b want 31 1", nb, cr_err);
      end
      do_reset();
      @(negedge clk);
      n_chk++; if (cr_err !== 1'b0) begin
         n_fail++; $display("FAIL sat_err_clear: cr_err=%b want 0", cr_err);
      end
   endtask

   task automatic test_reset_mid;
      int cnt[CH], expd[CH], nbeat[CH];
      logic first;
      logic [CH-1:0] ret;
      logic [CH*W-1:0] d;
      for (int i = 0; i < CH; i++) begin cnt[i] = 0; expd[i] = 0; nbeat[i] = 0; end
      ret = '0;
      do_reset();
      for (int cyc = 0; cyc < 12; cyc++) begin
         for (int i = 0; i < CH; i++) d[i*W +: W] = 8'(cnt[i]);
         step('1, d, ret);
         ret = '0;
         for (int i = 0; i < CH; i++) if (hs[i]) cnt[i]++;
         if (bv) ret[bvc] = 1'b1;
      end
      @(posedge clk); #2;
      n_chk++; if (p_vld !== 1'b1) begin
         n_fail++; $display("FAIL mid_pre_vld: p_vld=%b want 1", p_vld);
      end
      #1 reset = 1'b1;
      #1;
      n_chk++; if (p_vld !== 1'b0) begin
         n_fail++; $display("FAIL mid_async_vld: p_vld=%b want 0", p_vld);
      end
      c_srdy = '0; p_cr = '0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      for (int i = 0; i < CH; i++) cnt[i] = 0;
      first = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         for (int i = 0; i < CH; i++) d[i*W +: W] = 8'(cnt[i]);
         step('1, d, '0);
         for (int i = 0; i < CH; i++) if (hs[i]) cnt[i]++;
         if (bv) begin
            if (first) begin
               n_chk++; if (bvc !== 2'd0) begin
                  n_fail++; $display("FAIL mid_first_vc: got %0d want 0", bvc);
               end
               first = 1'b0;
            end
            n_chk++; if (bd !== 8'(expd[bvc])) begin
               n_fail++; $display("FAIL mid_data ch%0d: got %h want %h", bvc, bd, 8'(expd[bvc]));
            end
            expd[bvc]++;
            nbeat[bvc]++;
         end
      end
      for (int i = 0; i < CH; i++) begin
         n_chk++; if (nbeat[i] !== INIT) begin
            n_fail++; $display("FAIL mid_count ch%0d: got %0d want %0d", i, nbeat[i], INIT);
         end
      end
   endtask

   // Random traffic against a scoreboard: per-channel FIFO order, and the
   // number of words in flight never exceeds the credits granted.
   task automatic test_random;
      logic [W-1:0] q[CH][$];
      int owed[CH], outst[CH];
      logic [CH-1:0] ret, pend_ret, s;
      logic [CH*W-1:0] d;
      logic [W-1:0] e;
      for (int i = 0; i < CH; i++) begin owed[i] = 0; outst[i] = 0; end
      pend_ret = '0;
      do_reset();
      for (int cyc = 0; cyc < 1700; cyc++) begin
         s = (cyc < 1500) ? CH'($urandom) : '0;
         d = CH*W'($urandom);
         for (int i = 0; i < CH; i++) begin
            ret[i] = (owed[i] > 0) && (cyc >= 1500 || $urandom_range(0, 2) == 0);
            if (ret[i]) owed[i]--;
         end
         step(s, d, ret);
         if (bv) begin
            e = (q[bvc].size() > 0) ? q[bvc].pop_front() : ~bd;
            n_chk++; if (bd !== e) begin
               n_fail++; $display("FAIL rnd_data ch%0d cyc %0d: got %h want %h", bvc, cyc, bd, e);
            end
            outst[bvc]++;
            owed[bvc]++;
            n_chk++; if (outst[bvc] > INIT) begin
               n_fail++; $display("FAIL rnd_credit ch%0d cyc %0d: in flight %0d want <= %0d", bvc, cyc, outst[bvc], INIT);
            end
         end
         for (int i = 0; i < CH; i++) if (pend_ret[i]) outst[i]--;
         pend_ret = ret;
         for (int i = 0; i < CH; i++) if (hs[i]) q[i].push_back(c_data[i*W +: W]);
      end
      for (int i = 0; i < CH; i++) begin
         n_chk++; if (q[i].size() !== 0) begin
            n_fail++; $display("FAIL rnd_drain ch%0d: %0d words left want 0", i, q[i].size());
         end
      end
      n_chk++; if (c_drdy !== 4'hF || cr_err !== 1'b0) begin
         n_fail++; $display("FAIL rnd_idle: drdy=%h cr_err=%b want f 0", c_drdy, cr_err);
      end
   endtask

   initial begin
      test_reset();
      test_ch0_stream();
      test_all_saturated();
      test_credit_same_cycle();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
